sample_msg_demux: RTL and testbench

//  Generalised splitter: separates one framed input stream into N_CHANNELS sample streams plus one message stream.

---
 rtl/sample_msg_demux_pkg.sv | 28 ++
 rtl/sample_msg_demux_header_decode.sv | 30 +++
 rtl/sample_msg_demux.sv | 164 ++++++++++++++++
 tb/tb_sample_msg_demux.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sample_msg_demux_pkg.sv
// Shared definitions for sample_msg_demux: FSM encodings, header field helpers, error flag indices.
// Optional stall timeout is enabled by defining SPLITTER_TIMEOUT_EN.
package sample_msg_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_SMP  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam int MSG_DEST     = 0;
  localparam int ERR_STRAY    = 0;
  localparam int ERR_BAD_DEST = 1;
  localparam int ERR_ZERO_LEN = 2;
  localparam int ERR_TIMEOUT  = 3;

  // Header marker is always the MSB of the word.
  function automatic int hdr_flag_bit(input int wdth);
    return wdth - 1;
  endfunction

  // Destination field must encode the message port plus every sample channel.
  function automatic int dest_w(input int n_channels);
    return $clog2(n_channels + 1);
  endfunction

endpackage

// File: rtl/sample_msg_demux_header_decode.sv
// msg_header_decode: combinational header field extraction and header fault classification.
module msg_header_decode
  import sample_msg_demux_pkg::*;
#(
  parameter int WDTH       = 32,
  parameter int N_CHANNELS = 2,
  parameter int LEN_W      = 8,
  parameter int DEST_W     = dest_w(N_CHANNELS)
) (
  input  logic [WDTH-1:0]   data_i,
  output logic              is_hdr_o,
  output logic [DEST_W-1:0] dest_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              bad_dest_o,
  output logic              zero_len_o
);

  localparam logic [DEST_W-1:0] N_CH_L = DEST_W'(N_CHANNELS);

  assign is_hdr_o   = data_i[hdr_flag_bit(WDTH)];
  assign dest_o     = data_i[WDTH-2 -: DEST_W];
  assign len_o      = data_i[LEN_W-1:0];
  assign bad_dest_o = dest_o > N_CH_L;
  assign zero_len_o = len_o == '0;

  // Bits between the dest and len fields carry no meaning in a header.
  logic unused_bits;
  assign unused_bits = ^data_i;

endmodule

// File: rtl/sample_msg_demux.sv
// sample_msg_demux: splits one framed stream into N_CHANNELS sample streams plus a message stream.
// Define SPLITTER_TIMEOUT_EN to abort packets that stall for TIMEOUT cycles.
module sample_msg_demux
  import sample_msg_demux_pkg::*;
#(
  parameter int WDTH       = 32,
  parameter int N_CHANNELS = 2,
  parameter int LEN_W      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WDTH-1:0]       in_data,
  input  logic                  in_nd,
  output logic [WDTH-1:0]       out_samples,
  output logic [N_CHANNELS-1:0] out_samples_nd,
  output logic [WDTH-1:0]       out_msg,
  output logic                  out_msg_nd,
  output logic                  error,
  output logic [3:0]            error_flags
);

  localparam int DEST_W = dest_w(N_CHANNELS);
  localparam int CH_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic              hdr_is_hdr;
  logic [DEST_W-1:0] hdr_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_bad_dest;
  logic              hdr_zero_len;

  msg_header_decode #(
    .WDTH       (WDTH),
    .N_CHANNELS (N_CHANNELS),
    .LEN_W      (LEN_W),
    .DEST_W     (DEST_W)
  ) u_hdr (
    .data_i     (in_data),
    .is_hdr_o   (hdr_is_hdr),
    .dest_o     (hdr_dest),
    .len_o      (hdr_len),
    .bad_dest_o (hdr_bad_dest),
    .zero_len_o (hdr_zero_len)
  );

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]       chan_q, chan_d;
  logic [WDTH-1:0]       smp_q, smp_d;
  logic [N_CHANNELS-1:0] smp_nd_q, smp_nd_d;
  logic [WDTH-1:0]       msg_q, msg_d;
  logic                  msg_nd_q, msg_nd_d;
  logic                  err_q, err_d;
  logic [3:0]            flags_q, flags_d;

`ifdef SPLITTER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chan_d   = chan_q;
    smp_d    = smp_q;
    smp_nd_d = '0;
    msg_d    = msg_q;
    msg_nd_d = 1'b0;
    err_d    = 1'b0;
    flags_d  = flags_q;
`ifdef SPLITTER_TIMEOUT_EN
    // Stall timer reloads on every accepted word and whenever idle between packets.
    tmr_d    = TMR_W'(TIMEOUT);
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_nd) begin
          if (!hdr_is_hdr) begin
            err_d              = 1'b1;
            flags_d[ERR_STRAY] = 1'b1;
          end else if (hdr_zero_len) begin
            err_d                 = 1'b1;
            flags_d[ERR_ZERO_LEN] = 1'b1;
          end else if (hdr_bad_dest) begin
            err_d                 = 1'b1;
            flags_d[ERR_BAD_DEST] = 1'b1;
            cnt_d                 = hdr_len;
            state_d               = ST_DROP;
          end else if (hdr_dest == DEST_W'(MSG_DEST)) begin
            msg_d    = in_data;
            msg_nd_d = 1'b1;
            cnt_d    = hdr_len;
            state_d  = ST_MSG;
          end else begin
            chan_d  = CH_W'(hdr_dest - DEST_W'(1));
            cnt_d   = hdr_len;
            state_d = ST_SMP;
          end
        end
      end
      default: begin
        if (in_nd) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
          if (state_q == ST_MSG) begin
            msg_d    = in_data;
            msg_nd_d = 1'b1;
          end else if (state_q == ST_SMP) begin
            smp_d    = in_data;
            smp_nd_d = N_CHANNELS'(1) << chan_q;
          end
        end
`ifdef SPLITTER_TIMEOUT_EN
        else if (tmr_q == TMR_W'(1)) begin
          err_d                = 1'b1;
          flags_d[ERR_TIMEOUT] = 1'b1;
          cnt_d                = '0;
          state_d              = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      chan_q   <= '0;
      smp_q    <= '0;
      smp_nd_q <= '0;
      msg_q    <= '0;
      msg_nd_q <= 1'b0;
      err_q    <= 1'b0;
      flags_q  <= '0;
`ifdef SPLITTER_TIMEOUT_EN
      tmr_q    <= TMR_W'(TIMEOUT);
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      smp_q    <= smp_d;
      smp_nd_q <= smp_nd_d;
      msg_q    <= msg_d;
      msg_nd_q <= msg_nd_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
`ifdef SPLITTER_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  assign out_samples    = smp_q;
  assign out_samples_nd = smp_nd_q;
  assign out_msg        = msg_q;
  assign out_msg_nd     = msg_nd_q;
  assign error          = err_q;
  assign error_flags    = flags_q;

endmodule

// File: tb/tb_sample_msg_demux.sv
// Directed bench for sample_msg_demux (WDTH=32, N_CHANNELS=2, LEN_W=8); timeout case runs with SPLITTER_TIMEOUT_EN.
module tb_sample_msg_demux;

`ifdef SPLITTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_nd = 1'b0;
  logic [31:0] out_samples;
  logic [1:0]  out_samples_nd;
  logic [31:0] out_msg;
  logic        out_msg_nd;
  logic        error;
  logic [3:0]  error_flags;

  int n_chk = 0;
  int n_err = 0;

  sample_msg_demux #(
    .WDTH       (32),
    .N_CHANNELS (2),
    .LEN_W      (8),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_nd          (in_nd),
    .out_samples    (out_samples),
    .out_samples_nd (out_samples_nd),
    .out_msg        (out_msg),
    .out_msg_nd     (out_msg_nd),
    .error          (error),
    .error_flags    (error_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_snd, input logic [31:0] e_smp,
                            input logic e_mnd, input logic [31:0] e_msg, input logic e_err,
                            input logic [3:0] e_flags);
    chk({tag, ".snd"},   32'(out_samples_nd), 32'(e_snd));
    chk({tag, ".smp"},   out_samples, e_smp);
    chk({tag, ".mnd"},   32'(out_msg_nd), 32'(e_mnd));
    chk({tag, ".msg"},   out_msg, e_msg);
    chk({tag, ".err"},   32'(error), 32'(e_err));
    chk({tag, ".flags"}, 32'(error_flags), 32'(e_flags));
  endtask

  // Drive one cycle of input, then sample 1 ns after the capturing edge.
  task automatic step(input string tag, input logic nd, input logic [31:0] d,
                      input logic [1:0] e_snd, input logic [31:0] e_smp,
                      input logic e_mnd, input logic [31:0] e_msg, input logic e_err,
                      input logic [3:0] e_flags);
    @(negedge clk);
    in_nd   = nd;
    in_data = d;
    @(posedge clk);
    #1;
    check_outs(tag, e_snd, e_smp, e_mnd, e_msg, e_err, e_flags);
  endtask

  task automatic reset_cycle(input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    in_nd   = 1'b0;
    in_data = '0;
    @(posedge clk);
    #1;
    check_outs(tag, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    reset_cycle("rst0");

    // Channel 0 packet
    step("t1.hdr", 1, 32'hA000_0003, 2'b00, 32'h0,  0, 32'h0, 0, 4'b0000);
    step("t1.w0",  1, 32'h0000_0011, 2'b01, 32'h11, 0, 32'h0, 0, 4'b0000);
    step("t1.w1",  1, 32'h0000_0022, 2'b01, 32'h22, 0, 32'h0, 0, 4'b0000);
    step("t1.w2",  1, 32'h0000_0033, 2'b01, 32'h33, 0, 32'h0, 0, 4'b0000);

    // Message packet then back-to-back channel 1 packet
    step("t2.hdr", 1, 32'h8000_0002, 2'b00, 32'h33, 1, 32'h8000_0002, 0, 4'b0000);
    step("t2.w0",  1, 32'h0000_00AA, 2'b00, 32'h33, 1, 32'hAA, 0, 4'b0000);
    step("t2.w1",  1, 32'h0000_00BB, 2'b00, 32'h33, 1, 32'hBB, 0, 4'b0000);
    step("t2.hdr1",1, 32'hC000_0001, 2'b00, 32'h33, 0, 32'hBB, 0, 4'b0000);
    step("t2.w2",  1, 32'h8000_0044, 2'b10, 32'h8000_0044, 0, 32'hBB, 0, 4'b0000);
    step("t2.idle",0, 32'hFFFF_FFFF, 2'b00, 32'h8000_0044, 0, 32'hBB, 0, 4'b0000);

    // Bad destination: payload dropped, then a normal packet
    step("t3.hdr", 1, 32'hE000_0002, 2'b00, 32'h8000_0044, 0, 32'hBB, 1, 4'b0010);
    step("t3.d0",  1, 32'h0000_0001, 2'b00, 32'h8000_0044, 0, 32'hBB, 0, 4'b0010);
    step("t3.d1",  1, 32'h0000_0002, 2'b00, 32'h8000_0044, 0, 32'hBB, 0, 4'b0010);
    step("t3.hdr1",1, 32'hA000_0001, 2'b00, 32'h8000_0044, 0, 32'hBB, 0, 4'b0010);
    step("t3.w0",  1, 32'h0000_0009, 2'b01, 32'h9, 0, 32'hBB, 0, 4'b0010);

    // Zero length header and stray word
    step("t4.zlen", 1, 32'hA000_0000, 2'b00, 32'h9, 0, 32'hBB, 1, 4'b0110);
    step("t4.str",  1, 32'h0000_1234, 2'b00, 32'h9, 0, 32'hBB, 1, 4'b0111);
    step("t4.idle", 0, 32'h0,         2'b00, 32'h9, 0, 32'hBB, 0, 4'b0111);

    // Reset mid-packet; following data word is stray
    step("t5.hdr", 1, 32'hA000_0004, 2'b00, 32'h9, 0, 32'hBB, 0, 4'b0111);
    step("t5.w0",  1, 32'h0000_0001, 2'b01, 32'h1, 0, 32'hBB, 0, 4'b0111);
    reset_cycle("t5.rst");
    step("t5.str", 1, 32'h0000_0005, 2'b00, 32'h0, 0, 32'h0, 1, 4'b0001);

`ifdef SPLITTER_TIMEOUT_EN
    reset_cycle("t6.rst");
    step("t6.hdr", 1, 32'hA000_0003, 2'b00, 32'h0, 0, 32'h0, 0, 4'b0000);
    step("t6.w0",  1, 32'h0000_0001, 2'b01, 32'h1, 0, 32'h0, 0, 4'b0000);
    step("t6.i1",  0, 32'h0, 2'b00, 32'h1, 0, 32'h0, 0, 4'b0000);
    step("t6.i2",  0, 32'h0, 2'b00, 32'h1, 0, 32'h0, 0, 4'b0000);
    step("t6.i3",  0, 32'h0, 2'b00, 32'h1, 0, 32'h0, 0, 4'b0000);
    step("t6.i4",  0, 32'h0, 2'b00, 32'h1, 0, 32'h0, 1, 4'b1000);
    step("t6.mhdr",1, 32'h8000_0001, 2'b00, 32'h1, 1, 32'h8000_0001, 0, 4'b1000);
    step("t6.mw0", 1, 32'h0000_0007, 2'b00, 32'h1, 1, 32'h7, 0, 4'b1000);
`else
    // Without the timeout a stalled packet resumes after a long gap
    reset_cycle("t6.rst");
    step("t6.hdr", 1, 32'hA000_0002, 2'b00, 32'h0, 0, 32'h0, 0, 4'b0000);
    repeat (20) step("t6.gap", 0, 32'h0, 2'b00, 32'h0, 0, 32'h0, 0, 4'b0000);
    step("t6.w0",  1, 32'h0000_0077, 2'b01, 32'h77, 0, 32'h0, 0, 4'b0000);
    step("t6.w1",  1, 32'h0000_0078, 2'b01, 32'h78, 0, 32'h0, 0, 4'b0000);
    step("t6.nxt", 1, 32'h0000_0079, 2'b00, 32'h78, 0, 32'h0, 1, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
